// File: rtl/err_pkg.sv
// rtl/err_pkg.sv - shared types and constants for the weighted IR error computation
package err_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam int ACC_W  = 17;
   localparam int SAMP_W = 12;
   localparam int ERR_W  = 10;
   localparam int SHIFT  = 5;

   localparam logic [ERR_W-1:0] SAT_POS = 10'h1FF;
   localparam logic [ERR_W-1:0] SAT_NEG = 10'h200;

endpackage

// File: rtl/err_compute_sat10.sv
// rtl/err_compute_sat10.sv - clamps a signed accumulator value into the 10-bit signed error range
module sat10
   import err_pkg::*;
(
   input  logic signed [ACC_W-1:0] val_i,
   output logic        [ERR_W-1:0] sat_o
);

   // Clamp to [-512, 511]; in-range values keep their low bits unchanged.
   always_comb begin
      sat_o = val_i[ERR_W-1:0];
      if (val_i > 17'sd511) begin
         sat_o = SAT_POS;
      end else if (val_i < -17'sd512) begin
         sat_o = SAT_NEG;
      end
   end

endmodule

// File: rtl/err_compute.sv
// rtl/err_compute.sv - accumulates 8 weighted left/right IR samples into a saturated signed error
module err_compute
   import err_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              strt,
   input  logic              sample_vld,
   input  logic [SAMP_W-1:0] ir_sample,
   output logic              busy,
   output logic [ERR_W-1:0]  err_sat,
   output logic              err_vld
);

   state_t                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [2:0]               idx_q, idx_d;
   logic [ERR_W-1:0]         err_sat_q, err_sat_d;
   logic                     err_vld_q, err_vld_d;
   logic                     busy_q, busy_d;

   logic [ACC_W-1:0]         samp_ext;
   logic signed [ACC_W-1:0]  term;
   logic signed [ACC_W-1:0]  acc_sum;
   logic signed [ACC_W-1:0]  acc_shr;
   logic [ERR_W-1:0]         sat_val;

   // Pair index n>>1 selects the shift weight; odd n is the right sensor and subtracts.
   assign samp_ext = {{(ACC_W-SAMP_W){1'b0}}, ir_sample};
   assign term     = signed'(samp_ext << idx_q[2:1]);
   assign acc_sum  = idx_q[0] ? (acc_q - term) : (acc_q + term);
   assign acc_shr  = acc_sum >>> SHIFT;

   sat10 u_sat10 (
      .val_i (acc_shr),
      .sat_o (sat_val)
   );

   // Next-state, accumulator and output-register logic.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      err_sat_d = err_sat_q;
      case (state_q)
         S_IDLE: begin
            if (strt) begin
               state_d = S_ACCUM;
               acc_d   = '0;
               idx_d   = '0;
            end
         end
         S_ACCUM: begin
            if (strt) begin
               acc_d = '0;
               idx_d = '0;
            end else if (sample_vld) begin
               acc_d = acc_sum;
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d   = S_DONE;
                  err_sat_d = sat_val;
               end
            end
         end
         S_DONE: begin
            if (strt) begin
               state_d = S_ACCUM;
               acc_d   = '0;
               idx_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      err_vld_d = (state_d == S_DONE);
      busy_d    = (state_d != S_IDLE);
   end

   // State and registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         idx_q     <= '0;
         err_sat_q <= '0;
         err_vld_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         err_sat_q <= err_sat_d;
         err_vld_q <= err_vld_d;
         busy_q    <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign err_sat = err_sat_q;
   assign err_vld = err_vld_q;

endmodule

// File: doc/err_compute.md
ERR_COMPUTE -- requirements
Module: err_compute

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): none; all widths and weights are fixed constants in err_pkg.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 strt  input  1  single-cycle pulse; begins a new 8-sample error computation.
REQ-005 sample_vld  input  1  qualifies ir_sample for one cycle.
REQ-006 ir_sample  input  12  unsigned IR sensor reading.
REQ-007 busy  output  1  high while a computation is in progress.
REQ-008 err_sat  output  10  signed saturated error; consumed by downstream PID terms.
REQ-009 err_vld  output  1  single-cycle strobe marking a new err_sat value.

Function
REQ-010 States SHALL be IDLE, ACCUM and DONE.
REQ-011 IDLE: accept strt -> clear accumulator and sample index, go to ACCUM; ignore sample_vld.
REQ-012 ACCUM: each sample_vld SHALL add a signed weighted term to a 17-bit signed accumulator and increment a 3-bit sample index n (0..7).
REQ-013 Term for index n: pair p = n>>1, weight = 1<<p (1,2,4,8); even n adds +weight*ir_sample (left sensor), odd n adds -weight*ir_sample (right sensor).
REQ-014 Weighting SHALL use shifts only; accumulator SHALL NOT overflow (max magnitude 4095*15 = 61425).
REQ-015 The sample_vld with n = 7 SHALL move the FSM to DONE.
REQ-016 DONE (one cycle): err_sat SHALL be loaded with sat10(accum >>> 5) (arithmetic shift), err_vld high for exactly that cycle, FSM returns to IDLE.
REQ-017 Latency: err_vld SHALL be high in the cycle following the clock edge that captured the 8th sample.
REQ-018 sat10: values > 511 -> 10'h1FF; values < -512 -> 10'h200; otherwise low 10 bits.
REQ-019 err_sat SHALL hold its value between strobes; err_vld SHALL be low in all non-DONE cycles.
REQ-020 busy SHALL be high in ACCUM and DONE, low in IDLE.
REQ-021 strt in ACCUM SHALL restart: accumulator and index cleared, remain in ACCUM, no err_vld for the abandoned computation.
REQ-022 strt and sample_vld in the same cycle: strt wins, sample discarded.
REQ-023 strt in DONE SHALL still complete the strobe and SHALL start a new computation (next state ACCUM).
REQ-024 Gaps of any length between sample_vld pulses SHALL be tolerated.

Reset
REQ-025 rst_n low at a clock edge SHALL force IDLE, accumulator 0, index 0, err_sat 0, err_vld 0, busy 0.
REQ-026 Reset mid-computation SHALL discard partial results; no err_vld SHALL follow.

Structure
REQ-027 Package err_pkg SHALL hold the state enum, ACC_W=17, SHIFT=5, SAT_POS=10'h1FF, SAT_NEG=10'h200.
REQ-028 Saturation SHALL be a combinational sub-module sat10 (17-bit signed in, 10-bit signed out).
REQ-029 All outputs SHALL be registered.

Verification
REQ-030 strt; 8 samples, all left 12'hFFF, all right 0 -> accum 61425, >>>5 = 1919, err_sat 10'h1FF, one err_vld.
REQ-031 strt; all left 0, all right 12'hFFF -> accum -61425, >>>5 = -1920, err_sat 10'h200.
REQ-032 strt; n0 = 64, others 0 -> err_sat 10'd2; left = right = 12'h800 on every pair -> err_sat 0.
REQ-033 strt, 5 samples, strt again, 8 samples of case REQ-030 -> exactly one err_vld, err_sat 10'h1FF.
REQ-034 rst_n low after 4 samples, then 4 more samples without strt -> no err_vld, err_sat 0, busy 0.
REQ-035 strt with sample_vld same cycle, then 8 samples with gaps of 0-3 cycles -> first sample discarded, result matches 8-sample golden model.
